// File: rtl/node_row_mapper.sv
// Node-index to matrix-row mapper: builds a table that skips the reference (ground) node
// one entry per cycle, then answers registered lookups from downstream matrix-fill stages.
module node_row_mapper #(
  parameter int IDX_W     = 5,
  parameter int MAX_NODES = 31
) (
  input  logic             clk,
  input  logic             program_resetn,
  input  logic             start_process,
  output logic             end_process,
  input  logic [IDX_W-1:0] numNodes,
  input  logic [IDX_W-1:0] ground_node,
  input  logic [IDX_W-1:0] lookup_node,
  output logic [IDX_W-1:0] lookup_row,
  output logic             lookup_valid,
  output logic [IDX_W-1:0] num_rows,
  output logic             busy,
  output logic             map_err
);

  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO   = IDX_W'(2);
  localparam logic [IDX_W:0]   MAX_N = (IDX_W+1)'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_BUILD = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                            state_q, state_d;
  logic                              start_q;
  logic [IDX_W-1:0]                  n_q, n_d, g_q, g_d, i_q, i_d;
  logic [IDX_W-1:0]                  num_rows_q, num_rows_d;
  logic                              map_err_q, map_err_d;
  logic                              end_q, end_d, busy_q, busy_d;
  logic [MAX_NODES-1:0]              valid_q, valid_d;
  logic [MAX_NODES-1:0][IDX_W-1:0]   rows_q, rows_d;
  logic [IDX_W-1:0]                  lookup_row_q, lookup_row_d;
  logic                              lookup_valid_q, lookup_valid_d;
  logic                              start_edge_s;

  assign start_edge_s = start_process & ~start_q;

  // Next-state, table build and registered-output computation.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    g_d        = g_q;
    i_d        = i_q;
    num_rows_d = num_rows_q;
    map_err_d  = map_err_q;
    valid_d    = valid_q;
    rows_d     = rows_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge_s) begin
          n_d       = numNodes;
          g_d       = ground_node;
          valid_d   = '0;
          map_err_d = 1'b0;
          state_d   = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if ((n_q < TWO) || (g_q >= n_q) || ({1'b0, n_q} > MAX_N)) begin
          map_err_d  = 1'b1;
          num_rows_d = '0;
          state_d    = S_ERROR;
        end else begin
          num_rows_d = n_q - ONE;
          i_d        = '0;
          state_d    = S_BUILD;
        end
      end
      S_BUILD: begin
        // Rows below the ground node keep their index; rows above shift down by one.
        if (i_q < g_q) begin
          valid_d[i_q] = 1'b1;
          rows_d[i_q]  = i_q;
        end else if (i_q == g_q) begin
          valid_d[i_q] = 1'b0;
        end else begin
          valid_d[i_q] = 1'b1;
          rows_d[i_q]  = i_q - ONE;
        end
        i_d = i_q + ONE;
        if (i_q == (n_q - ONE)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUILD;
        end
      end
      S_DONE, S_ERROR: begin
        if (!start_process) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    end_d  = (state_d == S_DONE) || (state_d == S_ERROR);
    busy_d = (state_d == S_LATCH) || (state_d == S_BUILD);

    if ((state_q == S_DONE) && (lookup_node < n_q) && valid_q[lookup_node]) begin
      lookup_valid_d = 1'b1;
      lookup_row_d   = rows_q[lookup_node];
    end else begin
      lookup_valid_d = 1'b0;
      lookup_row_d   = '0;
    end
  end

  // State and output registers; start_q resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b1;
      n_q            <= '0;
      g_q            <= '0;
      i_q            <= '0;
      num_rows_q     <= '0;
      map_err_q      <= 1'b0;
      end_q          <= 1'b0;
      busy_q         <= 1'b0;
      valid_q        <= '0;
      rows_q         <= '0;
      lookup_row_q   <= '0;
      lookup_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_process;
      n_q            <= n_d;
      g_q            <= g_d;
      i_q            <= i_d;
      num_rows_q     <= num_rows_d;
      map_err_q      <= map_err_d;
      end_q          <= end_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
      rows_q         <= rows_d;
      lookup_row_q   <= lookup_row_d;
      lookup_valid_q <= lookup_valid_d;
    end
  end

  assign end_process  = end_q;
  assign busy         = busy_q;
  assign map_err      = map_err_q;
  assign num_rows     = num_rows_q;
  assign lookup_row   = lookup_row_q;
  assign lookup_valid = lookup_valid_q;

endmodule

// File: tb/tb_node_row_mapper.sv
// Directed and randomized bench for node_row_mapper against an arithmetic reference model.
module tb_node_row_mapper;

  logic       clk = 1'b0;
  logic       program_resetn;
  logic       start_process;
  logic       end_process;
  logic [4:0] numNodes, ground_node, lookup_node;
  logic [4:0] lookup_row, num_rows;
  logic       lookup_valid, busy, map_err;

  int total = 0;
  int bad   = 0;

  node_row_mapper #(.IDX_W(5), .MAX_NODES(31)) dut (
    .clk            (clk),
    .program_resetn (program_resetn),
    .start_process  (start_process),
    .end_process    (end_process),
    .numNodes       (numNodes),
    .ground_node    (ground_node),
    .lookup_node    (lookup_node),
    .lookup_row     (lookup_row),
    .lookup_valid   (lookup_valid),
    .num_rows       (num_rows),
    .busy           (busy),
    .map_err        (map_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: which matrix row a node lands on once the ground node is removed.
  function automatic bit cfg_err(input int n, input int g);
    return (n < 2) || (g >= n) || (n > 31);
  endfunction

  function automatic int ref_valid(input int n, input int g, input int k);
    return (!cfg_err(n, g) && k < n && k != g) ? 1 : 0;
  endfunction

  function automatic int ref_row(input int n, input int g, input int k);
    if (ref_valid(n, g, k) == 0) return 0;
    return (k < g) ? k : k - 1;
  endfunction

  task automatic check_table(input int n, input int g, input string tag);
    for (int k = 0; k < 32; k++) begin
      lookup_node = 5'(k);
      step();
      chk({tag, "_row"}, int'(lookup_row), ref_row(n, g, k));
      chk({tag, "_valid"}, int'(lookup_valid), ref_valid(n, g, k));
    end
  endtask

  task automatic do_build(input int n, input int g);
    int lat;
    bit err;
    err = cfg_err(n, g);
    lat = err ? 2 : n + 2;
    numNodes      = 5'(n);
    ground_node   = 5'(g);
    start_process = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      lookup_node = 5'($urandom_range(0, 31));
      step();
      numNodes    = 5'($urandom_range(0, 31));
      ground_node = 5'($urandom_range(0, 31));
      chk("lookup_during_build", int'(lookup_valid), 0);
      if (k == 1) chk("busy_latch", int'(busy), 1);
      if (k < lat) chk("end_early", int'(end_process), 0);
      else         chk("end_on_time", int'(end_process), 1);
    end
    chk("busy_done", int'(busy), 0);
    chk("num_rows", int'(num_rows), err ? 0 : n - 1);
    chk("map_err", int'(map_err), err ? 1 : 0);
    check_table(n, g, "lookup");
    chk("end_held", int'(end_process), 1);
    start_process = 1'b0;
    step();
    chk("end_drop", int'(end_process), 0);
    chk("map_err_kept", int'(map_err), err ? 1 : 0);
    chk("num_rows_kept", int'(num_rows), err ? 0 : n - 1);
    lookup_node = 5'(0);
    step();
    chk("lookup_idle", int'(lookup_valid), 0);
  endtask

  initial begin
    int n, g;
    program_resetn = 1'b0;
    start_process  = 1'b0;
    numNodes       = 5'd0;
    ground_node    = 5'd0;
    lookup_node    = 5'd0;
    #12;
    chk("rst_end", int'(end_process), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(map_err), 0);
    chk("rst_lv", int'(lookup_valid), 0);
    chk("rst_row", int'(lookup_row), 0);
    chk("rst_rows", int'(num_rows), 0);
    program_resetn = 1'b1;
    step();
    step();

    do_build(5, 2);
    do_build(4, 0);
    do_build(4, 3);
    do_build(3, 3);
    do_build(1, 0);
    do_build(6, 5);

    // Reset in the middle of an n=10 build, with start held through release.
    numNodes      = 5'd10;
    ground_node   = 5'd4;
    start_process = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("mid_busy", int'(busy), 1);
    #2 program_resetn = 1'b0;
    #1;
    chk("arst_end", int'(end_process), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_err", int'(map_err), 0);
    chk("arst_lv", int'(lookup_valid), 0);
    chk("arst_row", int'(lookup_row), 0);
    chk("arst_rows", int'(num_rows), 0);
    step();
    program_resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("no_restart_busy", int'(busy), 0);
      chk("no_restart_end", int'(end_process), 0);
    end
    start_process = 1'b0;
    step();

    do_build(31, 30);
    do_build(31, 0);
    do_build(2, 1);
    do_build(0, 0);
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 31);
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, (n > 0) ? n - 1 : 0);
      do_build(n, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
